ad7606_par_responder: RTL and testbench

- Cycle-accurate responder for the AD7606 parallel read interface: the ADC end of the bus our parallel read master drives.
- It samples eight 16-bit channel inputs on a CONVST rising edge, holds BUSY high for a programmable time, then returns channels 1..8 in order, one per CS/RD read strobe.
- Used for loopback/self-test builds and as a synthesizable bench model, in the same sys_clk_i domain as the read master.

---
 rtl/ad7606_par_responder.sv | 176 +++++++++++++++++
 tb/tb_ad7606_par_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_par_responder.sv
// AD7606 parallel-read ADC responder: latches 8 channels on CONVST, holds BUSY, serves CS/RD reads.
// Optional AD7606_TEST_PATTERN_EN replaces channel inputs with {conversion count, channel index}.
module ad7606_par_responder #(
  parameter int BUSY_CYCLES = 8,
  parameter int NUM_CH      = 8
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        convst_i,
  input  logic        cs_i,
  input  logic        rd_i,
  input  logic [15:0] ch1_data_i,
  input  logic [15:0] ch2_data_i,
  input  logic [15:0] ch3_data_i,
  input  logic [15:0] ch4_data_i,
  input  logic [15:0] ch5_data_i,
  input  logic [15:0] ch6_data_i,
  input  logic [15:0] ch7_data_i,
  input  logic [15:0] ch8_data_i,
  output logic        busy_o,
  output logic        frstdata_o,
  output logic [15:0] ad_data_o,
  output logic        ad_data_oe_o,
  output logic        overrun_o
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] busy_cnt_reg, busy_cnt_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             busy_reg, busy_next;
  logic             overrun_reg, overrun_next;
  logic             convst_q_reg;
  logic             rd_q_reg;
  logic [15:0]      hold_reg;
  logic [15:0]      shadow_reg [NUM_CH];
  logic             load_en;
  logic             conv_edge;
  logic             rd_rise;
  logic             read_active;
  logic [15:0]      rd_data;

  assign conv_edge   = convst_i & ~convst_q_reg;
  assign rd_rise     = ~cs_i & rd_i & ~rd_q_reg;
  assign read_active = ~cs_i & ~rd_i;

  always_comb begin
    state_next    = state_reg;
    busy_cnt_next = busy_cnt_reg;
    ptr_next      = ptr_reg;
    busy_next     = busy_reg;
    overrun_next  = 1'b0;
    load_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (conv_edge) begin
          load_en       = 1'b1;
          busy_cnt_next = CNT_W'(BUSY_CYCLES - 1);
          busy_next     = 1'b1;
          state_next    = ST_CONV;
        end
      end
      ST_CONV: begin
        // A second CONVST while converting is flagged but otherwise ignored.
        if (conv_edge) begin
          overrun_next = 1'b1;
        end
        if (busy_cnt_reg == '0) begin
          state_next = ST_READY;
          ptr_next   = '0;
          busy_next  = 1'b0;
        end else begin
          busy_cnt_next = busy_cnt_reg - CNT_W'(1);
        end
      end
      ST_READY: begin
        if (conv_edge) begin
          load_en       = 1'b1;
          busy_cnt_next = CNT_W'(BUSY_CYCLES - 1);
          busy_next     = 1'b1;
          state_next    = ST_CONV;
        end else if (rd_rise) begin
          ptr_next = (ptr_reg == PTR_W'(NUM_CH - 1)) ? '0 : ptr_reg + PTR_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= ST_IDLE;
      busy_cnt_reg <= '0;
      ptr_reg      <= '0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      convst_q_reg <= 1'b0;
      rd_q_reg     <= 1'b1;
      hold_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      busy_cnt_reg <= busy_cnt_next;
      ptr_reg      <= ptr_next;
      busy_reg     <= busy_next;
      overrun_reg  <= overrun_next;
      convst_q_reg <= convst_i;
      rd_q_reg     <= rd_i | cs_i;
      hold_reg     <= ad_data_o;
    end
  end

`ifdef AD7606_TEST_PATTERN_EN
  logic [11:0] conv_cnt_reg;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      conv_cnt_reg <= '0;
    end else if (load_en) begin
      conv_cnt_reg <= conv_cnt_reg + 12'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shadow
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          shadow_reg[gi] <= '0;
        end else if (load_en) begin
          shadow_reg[gi] <= {conv_cnt_reg, 4'(gi)};
        end
      end
    end
  endgenerate
`else
  logic [16*8-1:0] ch_bus;

  assign ch_bus = {ch8_data_i, ch7_data_i, ch6_data_i, ch5_data_i,
                   ch4_data_i, ch3_data_i, ch2_data_i, ch1_data_i};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_shadow
      logic [15:0] ch_val;
      if (gi < 8) begin : g_live
        assign ch_val = ch_bus[16*gi +: 16];
      end else begin : g_none
        assign ch_val = '0;
      end
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          shadow_reg[gi] <= '0;
        end else if (load_en) begin
          shadow_reg[gi] <= ch_val;
        end
      end
    end
  endgenerate
`endif

  // Zero-latency bus: the pointer only moves on the RD rising edge, so data is stable while RD is low.
  assign rd_data      = (state_reg == ST_READY) ? shadow_reg[ptr_reg] : 16'h0000;
  assign ad_data_o    = read_active ? rd_data : hold_reg;
  assign ad_data_oe_o = read_active;
  assign frstdata_o   = ~cs_i & (state_reg == ST_READY) & (ptr_reg == '0);
  assign busy_o       = busy_reg;
  assign overrun_o    = overrun_reg;

endmodule

// File: tb/tb_ad7606_par_responder.sv
// Directed bench for ad7606_par_responder; also valid with AD7606_TEST_PATTERN_EN defined.
module tb_ad7606_par_responder;

  logic        sys_clk_i = 1'b0;
  logic        rst_n_i;
  logic        convst_i;
  logic        cs_i;
  logic        rd_i;
  logic [15:0] ch_val [8];
  logic        busy_o;
  logic        frstdata_o;
  logic [15:0] ad_data_o;
  logic        ad_data_oe_o;
  logic        overrun_o;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  logic [15:0] latched [8];
  int          lat_cnt = 0;
  int          tb_cnt  = 0;
  int          n;

  always #5 sys_clk_i = ~sys_clk_i;

  ad7606_par_responder #(.BUSY_CYCLES(4), .NUM_CH(8)) dut (
    .sys_clk_i   (sys_clk_i),
    .rst_n_i     (rst_n_i),
    .convst_i    (convst_i),
    .cs_i        (cs_i),
    .rd_i        (rd_i),
    .ch1_data_i  (ch_val[0]),
    .ch2_data_i  (ch_val[1]),
    .ch3_data_i  (ch_val[2]),
    .ch4_data_i  (ch_val[3]),
    .ch5_data_i  (ch_val[4]),
    .ch6_data_i  (ch_val[5]),
    .ch7_data_i  (ch_val[6]),
    .ch8_data_i  (ch_val[7]),
    .busy_o      (busy_o),
    .frstdata_o  (frstdata_o),
    .ad_data_o   (ad_data_o),
    .ad_data_oe_o(ad_data_oe_o),
    .overrun_o   (overrun_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_val(input int k);
`ifdef AD7606_TEST_PATTERN_EN
    logic [11:0] c;
    logic [3:0]  kb;
    c  = 12'(lat_cnt);
    kb = 4'(k);
    return {c, kb};
`else
    return latched[k];
`endif
  endfunction

  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic set_ch_default();
    for (int k = 0; k < 8; k++) ch_val[k] = 16'h1111 * 16'(k + 1);
  endtask

  // Accepted conversion: remember what the responder should latch.
  task automatic conv_pulse();
    convst_i = 1'b1;
    for (int k = 0; k < 8; k++) latched[k] = ch_val[k];
    lat_cnt = tb_cnt;
    tb_cnt++;
    step();
    convst_i = 1'b0;
  endtask

  task automatic wait_busy_low(output int cnt);
    cnt = 0;
    while (busy_o && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  task automatic do_read(input string tag, input logic [15:0] exp_d, input logic exp_f);
    cs_i = 1'b0;
    rd_i = 1'b0;
    #3;
    $display("read %s: data=%h frst=%b oe=%b", tag, ad_data_o, frstdata_o, ad_data_oe_o);
    chk({tag, "_data"}, ad_data_o, exp_d);
    chk({tag, "_frst"}, 16'(frstdata_o), 16'(exp_f));
    chk({tag, "_oe"}, 16'(ad_data_oe_o), 16'h0001);
    step();
    rd_i = 1'b1;
    step();
    cs_i = 1'b1;
  endtask

  initial begin
    rst_n_i  = 1'b0;
    convst_i = 1'b0;
    cs_i     = 1'b1;
    rd_i     = 1'b1;
    set_ch_default();
    for (int k = 0; k < 8; k++) latched[k] = 16'h0000;
    repeat (3) step();
    chk("rst_busy", 16'(busy_o), 16'h0000);
    chk("rst_frst", 16'(frstdata_o), 16'h0000);
    chk("rst_data", ad_data_o, 16'h0000);
    chk("rst_oe", 16'(ad_data_oe_o), 16'h0000);
    chk("rst_ovr", 16'(overrun_o), 16'h0000);
    rst_n_i = 1'b1;
    step();

    // Basic conversion, eight reads, hold and wrap.
    conv_pulse();
    wait_busy_low(n);
    chk("basic_busy_len", 16'(n), 16'd4);
    for (int k = 0; k < 8; k++) do_read($sformatf("basic%0d", k), exp_val(k), k == 0);
    #3;
    chk("hold_data", ad_data_o, exp_val(7));
    chk("hold_oe", 16'(ad_data_oe_o), 16'h0000);
    step();
    do_read("wrap", exp_val(0), 1'b1);

    // Live inputs change during CONV, plus an overrun edge two cycles in.
    conv_pulse();
    for (int k = 0; k < 8; k++) ch_val[k] = 16'hFFFF;
    step();
    convst_i = 1'b1;
    chk("ovr_pre", 16'(overrun_o), 16'h0000);
    step();
    convst_i = 1'b0;
    chk("ovr_pulse", 16'(overrun_o), 16'h0001);
    chk("ovr_busy", 16'(busy_o), 16'h0001);
    step();
    chk("ovr_post", 16'(overrun_o), 16'h0000);
    wait_busy_low(n);
    chk("ovr_busy_tail", 16'(n), 16'd1);
    for (int k = 0; k < 8; k++) do_read($sformatf("live%0d", k), exp_val(k), k == 0);
    set_ch_default();
    step();

    // Read while busy, then CS masking of RD toggles.
    conv_pulse();
    do_read("busy_rd", 16'h0000, 1'b0);
    wait_busy_low(n);
    chk("busy_rd_len", 16'(n), 16'd2);
    do_read("after_busy", exp_val(0), 1'b1);
    rd_i = 1'b0;
    step();
    rd_i = 1'b1;
    step();
    rd_i = 1'b0;
    step();
    rd_i = 1'b1;
    step();
    do_read("cs_mask", exp_val(1), 1'b0);

    // Reset in the middle of a read sequence.
    conv_pulse();
    wait_busy_low(n);
    for (int k = 0; k < 3; k++) do_read($sformatf("pre_rst%0d", k), exp_val(k), k == 0);
    cs_i = 1'b0;
    rd_i = 1'b0;
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_data", ad_data_o, 16'h0000);
    chk("midrst_busy", 16'(busy_o), 16'h0000);
    chk("midrst_frst", 16'(frstdata_o), 16'h0000);
    chk("midrst_ovr", 16'(overrun_o), 16'h0000);
    step();
    cs_i = 1'b1;
    rd_i = 1'b1;
    step();
    rst_n_i = 1'b1;
    tb_cnt  = 0;
    step();
    do_read("post_rst", 16'h0000, 1'b0);

    // Two conversions; the second is checked against hand-computed values.
    conv_pulse();
    wait_busy_low(n);
    step();
    conv_pulse();
    wait_busy_low(n);
    chk("conv2_busy_len", 16'(n), 16'd4);
    for (int k = 0; k < 8; k++) begin
`ifdef AD7606_TEST_PATTERN_EN
      do_read($sformatf("conv2_%0d", k), 16'h0010 + 16'(k), k == 0);
`else
      do_read($sformatf("conv2_%0d", k), 16'h1111 * 16'(k + 1), k == 0);
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
